dphy_tx_lane_sequencer: RTL

//  Synthesizable D-PHY data-lane start/end-of-transmission sequencer on the byte clock.

---
 rtl/dphy_tx_lane_sequencer_if.sv | 23 ++
 rtl/dphy_tx_lane_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dphy_tx_lane_sequencer_if.sv
// ---------------------------------------------------------------------------
// dphy_tx_lane_sequencer_if
//   Payload byte stream feeding the D-PHY data-lane sequencer.
//   Signals:
//     tx_data  : payload byte
//     tx_valid : tx_data is valid
//     tx_last  : qualifies the final payload byte of a burst (with tx_valid)
//     tx_ready : byte accepted when tx_valid & tx_ready
//   Modports:
//     master : byte source (drives data/valid/last, observes ready)
//     slave  : the sequencer (observes data/valid/last, drives ready)
// ---------------------------------------------------------------------------
interface dphy_tx_lane_sequencer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/dphy_tx_lane_sequencer.sv
// ---------------------------------------------------------------------------
// dphy_tx_lane_sequencer
//   D-PHY data-lane start/end-of-transmission sequencer on the byte clock.
//   LP11 -> LP01 -> LP00 -> HS-zero -> SYNC -> payload -> HS-trail -> LP11.
//   Ports:
//     clk_i, rst_n_i  : byte clock, asynchronous active-low reset
//     hs_req_i        : burst request (level, sampled when idle)
//     clk_hs_ready_i  : clock lane in HS mode; gates the burst start
//     tx              : payload stream (slave side)
//     lp_p_o, lp_n_o  : LP driver levels
//     hs_en_o         : HS driver enable
//     hs_data_o       : byte to the HS serializer (sent LSB first)
//     busy_o          : high whenever not idle
//     done_o          : one-cycle pulse in the final EXIT cycle
//     underflow_o     : one-cycle pulse when the payload starves mid-burst
//   Every output is a register loaded from the decode of the next state, so
//   each output is aligned with the state it belongs to.
// ---------------------------------------------------------------------------
module dphy_tx_lane_sequencer #(
  parameter int                DATA_W       = 8,
  parameter int                T_LPX        = 3,
  parameter int                T_HS_PREPARE = 4,
  parameter int                T_HS_ZERO    = 6,
  parameter int                T_HS_TRAIL   = 4,
  parameter int                T_HS_EXIT    = 6,
  parameter logic [DATA_W-1:0] SYNC_BYTE    = 8'hB8
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   hs_req_i,
  input  logic                   clk_hs_ready_i,
  dphy_tx_lane_sequencer_if.slave tx,
  output logic                   lp_p_o,
  output logic                   lp_n_o,
  output logic                   hs_en_o,
  output logic [DATA_W-1:0]      hs_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   underflow_o
);

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LPX   = 3'd1,
    PREP  = 3'd2,
    ZERO  = 3'd3,
    SYNC  = 3'd4,
    DATA  = 3'd5,
    TRAIL = 3'd6,
    EXIT  = 3'd7
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  timer_r, timer_s;
  logic              ending_r, ending_s;   // last byte accepted, now being driven
  logic              last_bit_r, last_bit_s;
  logic              accept_s;
  logic              underflow_s;

  logic              lp_p_s, lp_n_s, hs_en_s, ready_s, busy_s, done_s;
  logic [DATA_W-1:0] hs_data_s;
  logic              ready_r;

  // Timer reload value (N-1) for the state being entered.
  function automatic logic [CNT_W-1:0] load_val(input state_t s);
    case (s)
      LPX:     load_val = CNT_W'(T_LPX - 1);
      PREP:    load_val = CNT_W'(T_HS_PREPARE - 1);
      ZERO:    load_val = CNT_W'(T_HS_ZERO - 1);
      TRAIL:   load_val = CNT_W'(T_HS_TRAIL - 1);
      EXIT:    load_val = CNT_W'(T_HS_EXIT - 1);
      default: load_val = {CNT_W{1'b0}};
    endcase
  endfunction

  // Next-state, timer and payload bookkeeping.
  always_comb begin
    state_s     = state_r;
    ending_s    = 1'b0;
    last_bit_s  = last_bit_r;
    accept_s    = 1'b0;
    underflow_s = 1'b0;
    if (timer_r != {CNT_W{1'b0}}) begin
      timer_s = timer_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      timer_s = timer_r;
    end

    case (state_r)
      IDLE: begin
        if (hs_req_i && clk_hs_ready_i) state_s = LPX;
        else                            state_s = IDLE;
      end
      LPX: begin
        if (timer_r == {CNT_W{1'b0}}) state_s = PREP;
        else                          state_s = LPX;
      end
      PREP: begin
        if (timer_r == {CNT_W{1'b0}}) state_s = ZERO;
        else                          state_s = PREP;
      end
      ZERO: begin
        if (timer_r == {CNT_W{1'b0}}) state_s = SYNC;
        else                          state_s = ZERO;
      end
      SYNC: begin
        // Byte 0 is taken here; if it is missing the burst closes with the
        // sync byte as the last transmitted byte.
        if (tx.tx_valid) begin
          accept_s   = 1'b1;
          last_bit_s = tx.tx_data[DATA_W-1];
          ending_s   = tx.tx_last;
          state_s    = DATA;
        end else begin
          underflow_s = 1'b1;
          last_bit_s  = SYNC_BYTE[DATA_W-1];
          state_s     = TRAIL;
        end
      end
      DATA: begin
        if (ending_r) begin
          state_s = TRAIL;
        end else if (tx.tx_valid) begin
          accept_s   = 1'b1;
          last_bit_s = tx.tx_data[DATA_W-1];
          ending_s   = tx.tx_last;
          state_s    = DATA;
        end else begin
          underflow_s = 1'b1;
          state_s     = TRAIL;
        end
      end
      TRAIL: begin
        if (timer_r == {CNT_W{1'b0}}) state_s = EXIT;
        else                          state_s = TRAIL;
      end
      EXIT: begin
        // The last EXIT cycle doubles as the idle sample point, so a held
        // request restarts after exactly T_HS_EXIT LP11 cycles.
        if (timer_r != {CNT_W{1'b0}})            state_s = EXIT;
        else if (hs_req_i && clk_hs_ready_i)     state_s = LPX;
        else                                     state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase

    if (state_s != state_r) begin
      timer_s = load_val(state_s);
    end else begin
      timer_s = timer_s;
    end
  end

  // Output decode of the next state (registered below).
  always_comb begin
    lp_p_s    = 1'b1;
    lp_n_s    = 1'b1;
    hs_en_s   = 1'b0;
    hs_data_s = {DATA_W{1'b0}};
    ready_s   = 1'b0;
    busy_s    = (state_s != IDLE);
    done_s    = (state_s == EXIT) && (timer_s == {CNT_W{1'b0}});
    case (state_s)
      LPX: begin
        lp_p_s = 1'b0;
      end
      PREP: begin
        lp_p_s = 1'b0;
        lp_n_s = 1'b0;
      end
      ZERO: begin
        lp_p_s  = 1'b0;
        lp_n_s  = 1'b0;
        hs_en_s = 1'b1;
      end
      SYNC: begin
        lp_p_s    = 1'b0;
        lp_n_s    = 1'b0;
        hs_en_s   = 1'b1;
        hs_data_s = SYNC_BYTE;
        ready_s   = 1'b1;
      end
      DATA: begin
        lp_p_s  = 1'b0;
        lp_n_s  = 1'b0;
        hs_en_s = 1'b1;
        if (accept_s) hs_data_s = tx.tx_data;
        else          hs_data_s = hs_data_o;
        ready_s = ~ending_s;
      end
      TRAIL: begin
        lp_p_s    = 1'b0;
        lp_n_s    = 1'b0;
        hs_en_s   = 1'b1;
        hs_data_s = {DATA_W{~last_bit_s}};
      end
      default: begin
        lp_p_s = 1'b1;
        lp_n_s = 1'b1;
      end
    endcase
  end

  // State, timer and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= IDLE;
      timer_r     <= {CNT_W{1'b0}};
      ending_r    <= 1'b0;
      last_bit_r  <= 1'b0;
      lp_p_o      <= 1'b1;
      lp_n_o      <= 1'b1;
      hs_en_o     <= 1'b0;
      hs_data_o   <= {DATA_W{1'b0}};
      ready_r     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      state_r     <= state_s;
      timer_r     <= timer_s;
      ending_r    <= ending_s;
      last_bit_r  <= last_bit_s;
      lp_p_o      <= lp_p_s;
      lp_n_o      <= lp_n_s;
      hs_en_o     <= hs_en_s;
      hs_data_o   <= hs_data_s;
      ready_r     <= ready_s;
      busy_o      <= busy_s;
      done_o      <= done_s;
      underflow_o <= underflow_s;
    end
  end

  assign tx.tx_ready = ready_r;

endmodule
